// File: rtl/event_sync_multi.sv
// Multi-channel event synchronizer: per-channel sync chain, debounce filter, edge-mode pulse
// generation and sticky pending/overrun flags for slow consumers.
module event_sync_multi #(
   parameter int unsigned          CHANNELS        = 4,
   parameter int unsigned          SYNC_STAGES     = 3,
   parameter int unsigned          DEBOUNCE_CYCLES = 16,
   parameter logic [2*CHANNELS-1:0] EDGE_MODE       = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] async_in,
   input  logic [CHANNELS-1:0] clear,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] pulse_out,
   output logic                any_event,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] overrun
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CntW-1:0]     cnt_d  [CHANNELS];
   logic [CntW-1:0]     cnt_q  [CHANNELS];
   logic [CHANNELS-1:0] stable_d, stable_q;
   logic [CHANNELS-1:0] stable_dly_d, stable_dly_q;
   logic [CHANNELS-1:0] pulse_d, pulse_q;
   logic                any_d, any_q;
   logic [CHANNELS-1:0] pending_d, pending_q;
   logic [CHANNELS-1:0] overrun_d, overrun_q;
   logic [CHANNELS-1:0] sync_last;
   logic [CHANNELS-1:0] rise, fall;

   always_comb begin
      sync_d[0] = async_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

   // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (sync_last[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = sync_last[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   assign stable_dly_d = stable_q;
   assign rise         = stable_q & ~stable_dly_q;
   assign fall         = ~stable_q & stable_dly_q;

   always_comb begin
      pulse_d = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         case (EDGE_MODE[2*i +: 2])
            2'b00:   pulse_d[i] = rise[i];
            2'b01:   pulse_d[i] = fall[i];
            2'b10:   pulse_d[i] = rise[i] | fall[i];
            default: pulse_d[i] = 1'b0;
         endcase
      end
      any_d = |pulse_d;
   end

   // A pulse always sets pending, even when acknowledged in the same cycle, so no event is lost.
   always_comb begin
      pending_d = pulse_q | (pending_q & ~clear);
      overrun_d = ~clear & (overrun_q | (pulse_q & pending_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= '0;
         end
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= '0;
         end
         stable_q     <= '0;
         stable_dly_q <= '0;
         pulse_q      <= '0;
         any_q        <= 1'b0;
         pending_q    <= '0;
         overrun_q    <= '0;
      end else begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= sync_d[s];
         end
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         pulse_q      <= pulse_d;
         any_q        <= any_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
      end
   end

   assign level_out = stable_q;
   assign pulse_out = pulse_q;
   assign any_event = any_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/event_sync_multi.md
Name: event_sync_multi

Overview:
Multi-channel synchronizer for asynchronous event lines such as pinball flipper buttons, target switches and galvo/laser status lines. It brings them into the projector clock domain, debounces them, and converts qualified edges into single-cycle pulses per a per-channel edge mode. Per-channel sticky pending/overrun flags let slow consumers (game FSM, frame scheduler) pick up events without missing them. It replaces ad-hoc one-off synchronizers with one parametrised block.

Parameters:
CHANNELS, 4, number of independent event inputs (1..32).
SYNC_STAGES, 3, synchronizer flop depth per channel (minimum 2).
DEBOUNCE_CYCLES, 16, consecutive cycles a new synchronized value must persist before it is accepted (minimum 1; 1 means no filtering beyond one cycle).
EDGE_MODE, {CHANNELS{2'b00}}, 2 bits per channel, channel i at [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled (no pulses, level still tracked).

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
async_in  input  CHANNELS  raw asynchronous event lines.
clear  input  CHANNELS  per-channel acknowledge; clears pending and overrun.
level_out  output  CHANNELS  debounced stable level.
pulse_out  output  CHANNELS  one-cycle qualified-edge pulse.
any_event  output  1  OR of pulse_out, same cycle.
pending  output  CHANNELS  sticky "event occurred" flag.
overrun  output  CHANNELS  sticky "event occurred while pending already set".

Behaviour:
- Reset: asynchronous on rst_n low. Every flop is 0: sync chain, stable level, debounce counter, pulse_out, any_event, pending, overrun. Deassertion takes effect on the next clk edge.
- Sync chain: async_in[i] shifts through SYNC_STAGES flops. The last stage is sync[i]. No logic sits between stages.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES)+1:
  - sync == stable: counter <= 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any return to equality before acceptance discards the transition. level_out = stable.
- Edge qualification: rise = stable changed 0->1 this edge; fall = stable changed 1->0. The mode selects rise, fall, rise|fall, or nothing. pulse_out is registered: high for exactly one cycle, the cycle after stable changes.
- Latency: if async_in changes before edge k, sync changes after edge k+SYNC_STAGES-1, stable after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, and pulse_out is high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES. For example, with 3/4 the input is sampled at edge 1, level_out rises after edge 7, and pulse_out is high after edge 8 only.
- any_event is registered alongside pulse_out, so it is never offset from it.
- Sticky flags, per channel, evaluated on pulse_out being high:
  - pulse, not pending: pending <= 1.
  - pulse, pending, no clear: overrun <= 1, pending stays 1.
  - clear, no pulse: pending <= 0, overrun <= 0.
  - pulse and clear same cycle: pending <= 1, overrun <= 0 (set wins, new event not lost).
  - clear with nothing pending: no effect.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle with no arbitration.
- A line held high through reset is seen as a rising transition after reset release, because stable resets to 0. In rising or both mode it produces one pulse at the normal latency. This is intended: initial switch state is reported.
- Reset mid-debounce: the counter and partial state are discarded, with no pulse either during or after reset unless the input is still at the new level afterwards.

Test Plan:
1. CHANNELS=4, SYNC_STAGES=3, DEBOUNCE_CYCLES=4; raise async_in[0] before edge 1 and hold -> level_out[0]=1 after edge 7; pulse_out[0]=any_event=1 after edge 8 only; pending[0]=1 from edge 9.
2. async_in[1] high for 3 cycles then low -> level_out[1], pulse_out[1], pending[1] stay 0; a subsequent 6-cycle high yields exactly one pulse.
3. EDGE_MODE ch2=10, ch3=01; pulse both lines high 10 cycles then low -> ch2 gives two pulses 10 cycles apart; ch3 gives only the falling-edge pulse; a ch with mode 11 gives no pulse, but level_out still follows.
4. Two qualified events on ch0 without clear -> pending[0]=1, overrun[0]=1; clear[0] one cycle -> both 0 next cycle; a third event with clear[0] in its pulse cycle -> pending=1, overrun=0.
5. Hold async_in[0] high, drop rst_n mid-debounce (counter=2) -> all outputs 0 immediately. Release with input low -> no pulse. Release with input high -> one pulse at full latency from the release edge.
6. All four inputs rise in the same cycle -> pulse_out=4'b1111 in one cycle; any_event high exactly one cycle; pending=4'b1111.
